// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg: shared state encoding, opcode nibbles and ctrl bit indices for the sequenced instruction decoder
package seq_decoder_pkg;
  localparam int N_CTRL = 11;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_INCREMENT, S_HALT} state_t;
  localparam logic [3:0] OP_OP = 4'h5;
  localparam logic [3:0] OP_ILL6 = 4'h6;
  localparam logic [3:0] OP_ILL7 = 4'h7;
  localparam logic [3:0] OP_JUMP = 4'h8;
  localparam logic [3:0] OP_JUMPNC = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int C_JUMP = 6;
  localparam int C_JUMPZ = 7;
  localparam int C_JUMPNZ = 8;
  localparam int C_JUMPC = 9;
  localparam int C_JUMPNC = 10;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: opcode nibble -> one-hot ctrl (opcodes 0-5 map to bits 0-5, 8-C to bits 6-10), is_halt, is_illegal
module opcode_decoder
  import seq_decoder_pkg::*;
(
  input  logic [3:0]        opcode,
  output logic [N_CTRL-1:0] ctrl,
  output logic              is_halt,
  output logic              is_illegal
);
  assign ctrl = (opcode <= OP_OP) ? N_CTRL'(1) << opcode :
                (opcode >= OP_JUMP && opcode <= OP_JUMPNC) ? N_CTRL'(1) << (opcode - 4'd2) : '0;
  assign is_halt = opcode == OP_HALT;
  assign is_illegal = opcode == OP_ILL6 || opcode == OP_ILL7 || opcode == OP_ILLD;
endmodule

// File: rtl/sequenced_instruction_decoder.sv
// sequenced_instruction_decoder: fetch/decode/execute/increment/halt sequencer driving one-hot ctrl, phase strobes, pc_load, halted, sticky illegal
module sequenced_instruction_decoder #(
  parameter int DATA_W = 8,
  parameter int EXEC_CYCLES = 1,
  parameter int N_CTRL = 11
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              clock_enable,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              resume,
  output logic              fetch,
  output logic              decode,
  output logic              execute,
  output logic              increment,
  output logic [N_CTRL-1:0] ctrl,
  output logic [DATA_W-5:0] operand,
  output logic              pc_load,
  output logic              halted,
  output logic              illegal
);
  import seq_decoder_pkg::*;
  localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  state_t state, state_nx;
  logic [DATA_W-1:0] ir;
  logic [CW-1:0] cnt;
  logic [N_CTRL-1:0] dec_ctrl;
  logic dec_halt, dec_ill, last;
  opcode_decoder u_dec (
    .opcode    (ir[DATA_W-1 -: 4]),
    .ctrl      (dec_ctrl),
    .is_halt   (dec_halt),
    .is_illegal(dec_ill)
  );
  assign last = state == S_EXECUTE && cnt == '0;
  assign fetch = state == S_FETCH;
  assign decode = state == S_DECODE;
  assign execute = state == S_EXECUTE;
  assign increment = state == S_INCREMENT;
  assign halted = state == S_HALT;
  assign operand = ir[DATA_W-5:0];
  assign pc_load = last & (ctrl[C_JUMP] | (ctrl[C_JUMPZ] & flag_z) | (ctrl[C_JUMPNZ] & ~flag_z) |
                           (ctrl[C_JUMPC] & flag_c) | (ctrl[C_JUMPNC] & ~flag_c));
  always_comb begin
    state_nx = state;
    state_nx = (state == S_FETCH) ? (mem_ready ? S_DECODE : S_FETCH) :
               (state == S_DECODE) ? S_EXECUTE :
               (state == S_EXECUTE) ? (cnt != '0 ? S_EXECUTE : dec_halt ? S_HALT : S_INCREMENT) :
               (state == S_HALT) ? (resume ? S_INCREMENT : S_HALT) : S_FETCH;
  end
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= S_FETCH;
      ir <= '0;
      cnt <= '0;
      ctrl <= '0;
      illegal <= 1'b0;
    end else if (clock_enable) begin
      state <= state_nx;
      if (state == S_FETCH && mem_ready) ir <= instr;
      cnt <= (state == S_DECODE) ? CW'(EXEC_CYCLES - 1) : (state == S_EXECUTE && cnt != '0) ? cnt - CW'(1) : cnt;
      ctrl <= (state == S_DECODE) ? dec_ctrl : last ? '0 : ctrl;
      if (state == S_DECODE && dec_ill) illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sequenced_instruction_decoder.sv
// tb_sequenced_instruction_decoder: two instances (EXEC_CYCLES 1 and 3) on shared inputs checked against an instruction-position model
module tb_sequenced_instruction_decoder;
  localparam int EC0 = 1;
  localparam int EC1 = 3;
  logic clock = 1'b0;
  logic clear_n = 1'b0, clock_enable = 1'b1, mem_ready = 1'b0, flag_z = 1'b0, flag_c = 1'b0, resume = 1'b0;
  logic [7:0] instr = '0;
  logic f0, d0, e0, i0, pl0, h0, il0, f1, d1, e1, i1, pl1, h1, il1;
  logic [10:0] c0, c1;
  logic [3:0] o0, o1;
  int vectors = 0, miscompares = 0, cycle = 0;
  int t [2];
  logic [7:0] mir [2];
  logic mill [2];
  bit chk = 1'b0;
  always #5 clock = ~clock;
  sequenced_instruction_decoder #(.DATA_W(8), .EXEC_CYCLES(EC0), .N_CTRL(11)) dut0 (
    .clock(clock), .clear_n(clear_n), .clock_enable(clock_enable), .instr(instr), .mem_ready(mem_ready),
    .flag_z(flag_z), .flag_c(flag_c), .resume(resume), .fetch(f0), .decode(d0), .execute(e0), .increment(i0),
    .ctrl(c0), .operand(o0), .pc_load(pl0), .halted(h0), .illegal(il0));
  sequenced_instruction_decoder #(.DATA_W(8), .EXEC_CYCLES(EC1), .N_CTRL(11)) dut1 (
    .clock(clock), .clear_n(clear_n), .clock_enable(clock_enable), .instr(instr), .mem_ready(mem_ready),
    .flag_z(flag_z), .flag_c(flag_c), .resume(resume), .fetch(f1), .decode(d1), .execute(e1), .increment(i1),
    .ctrl(c1), .operand(o1), .pc_load(pl1), .halted(h1), .illegal(il1));
  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, exp);
    end
  endtask
  function automatic int ec(int k);
    return k ? EC1 : EC0;
  endfunction
  function automatic logic [10:0] ctrl_of(logic [3:0] op);
    case (op)
      4'h0: return 11'h001;
      4'h1: return 11'h002;
      4'h2: return 11'h004;
      4'h3: return 11'h008;
      4'h4: return 11'h010;
      4'h5: return 11'h020;
      4'h8: return 11'h040;
      4'h9: return 11'h080;
      4'hA: return 11'h100;
      4'hB: return 11'h200;
      4'hC: return 11'h400;
      default: return 11'h000;
    endcase
  endfunction
  function automatic logic taken(logic [3:0] op);
    case (op)
      4'h8: return 1'b1;
      4'h9: return flag_z;
      4'hA: return !flag_z;
      4'hB: return flag_c;
      4'hC: return !flag_c;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [21:0] expv(int k);
    int e = ec(k);
    int tt = t[k];
    logic [3:0] op = mir[k][7:4];
    logic ex = tt >= 2 && tt <= 1 + e;
    return {tt == 0, tt == 1, ex, tt == 2 + e, ex ? ctrl_of(op) : 11'h000, mir[k][3:0],
            tt == 1 + e && taken(op), tt < 0, mill[k]};
  endfunction
  task automatic adv(int k);
    int e = ec(k);
    if (!clear_n) begin
      t[k] = 0;
      mir[k] = '0;
      mill[k] = 1'b0;
    end else if (clock_enable) begin
      if (t[k] == 0) begin
        if (mem_ready) begin
          mir[k] = instr;
          t[k] = 1;
        end
      end else if (t[k] < 0) begin
        if (resume) t[k] = 2 + e;
      end else if (t[k] == 1 + e) t[k] = (mir[k][7:4] == 4'hF) ? -1 : t[k] + 1;
      else if (t[k] == 2 + e) t[k] = 0;
      else begin
        if (t[k] == 1 && mir[k][7:4] inside {4'h6, 4'h7, 4'hD}) mill[k] = 1'b1;
        t[k]++;
      end
    end
  endtask
  task automatic cyc(input logic [7:0] i, input logic mr, z, c, rs, ce, cl);
    instr = i; mem_ready = mr; flag_z = z; flag_c = c; resume = rs; clock_enable = ce; clear_n = cl;
    @(negedge clock);
    if (chk) begin
      check("ec1", {f0, d0, e0, i0, c0, o0, pl0, h0, il0}, expv(0));
      check("ec3", {f1, d1, e1, i1, c1, o1, pl1, h1, il1}, expv(1));
    end
    @(posedge clock);
    adv(0);
    adv(1);
    cycle++;
    #1;
  endtask
  task automatic run(input logic [7:0] i, input logic mr, z, c, input int n);
    for (int j = 0; j < n; j++) cyc(i, mr, z, c, 1'b0, 1'b1, 1'b1);
  endtask
  initial begin
    #1;
    cyc(8'h00, 0, 0, 0, 0, 1, 0);
    cyc(8'h00, 0, 0, 0, 0, 1, 0);
    chk = 1'b1;
    run(8'h10, 1, 0, 0, 8);
    run(8'h25, 0, 0, 0, 3);
    run(8'h25, 1, 0, 0, 8);
    run(8'h9A, 1, 1, 0, 8);
    run(8'h9A, 1, 0, 0, 8);
    run(8'hAA, 1, 1, 0, 8);
    run(8'hAA, 1, 0, 0, 8);
    run(8'hBA, 1, 0, 1, 8);
    run(8'hBA, 1, 0, 0, 8);
    run(8'hCA, 1, 0, 1, 8);
    run(8'hCA, 1, 0, 0, 8);
    run(8'h8A, 1, 0, 0, 8);
    run(8'h30, 1, 0, 0, 12);
    run(8'hF0, 1, 0, 0, 14);
    cyc(8'h70, 1, 0, 0, 1, 1, 1);
    run(8'h70, 1, 0, 0, 10);
    run(8'hE3, 1, 0, 0, 10);
    run(8'h30, 1, 0, 0, 3);
    cyc(8'h30, 1, 0, 0, 0, 1, 0);
    run(8'h70, 1, 0, 0, 6);
    run(8'hF0, 1, 0, 0, 12);
    cyc(8'hF0, 1, 0, 0, 0, 1, 0);
    run(8'h30, 1, 0, 0, 3);
    for (int j = 0; j < 5; j++) cyc(8'h30, 1, 0, 0, 0, 0, 1);
    run(8'h30, 1, 0, 0, 8);
    for (int j = 0; j < 400; j++)
      cyc(8'($urandom), $urandom_range(3) != 0, 1'($urandom), 1'($urandom), $urandom_range(4) == 0,
          $urandom_range(9) != 0, $urandom_range(49) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
